// File: rtl/hob_ram_pkg.sv
// hob_ram_pkg: shared defaults, named memory shapes and the clear-sweep state
// type for the hob_ram simple dual-port RAM.
package hob_ram_pkg;

    // Default shape: perceptron weight table
    localparam int DEFAULT_WIDTH      = 36;
    localparam int DEFAULT_DEPTH      = 64;
    localparam int DEFAULT_INIT_VALUE = 0;

    // Named configurations served by the same block
    localparam int HOB_WIDTH  = 36;
    localparam int HOB_DEPTH  = 64;
    localparam int INSN_WIDTH = 32;
    localparam int INSN_DEPTH = 256;
    localparam int RAS_WIDTH  = 32;
    localparam int RAS_DEPTH  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/hob_ram_init.sv
// hob_ram_init: clear-sweep state machine. Reset parks the counter at 0;
// each following cycle clears one location until DEPTH-1 has been written.
module hob_ram_init
    import hob_ram_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_wren
);

    sweep_state_t state;

    // Sweep sequencer: reset (re)starts at 0, last address returns to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_busy <= 1'b1;
            clr_wren  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    init_busy <= 1'b0;
                    clr_wren  <= 1'b0;
                end
                CLEAR: begin
                    if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                        state     <= IDLE;
                        clr_addr  <= '0;
                        init_busy <= 1'b0;
                        clr_wren  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    init_busy <= 1'b0;
                    clr_wren  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hob_ram.sv
// hob_ram: simple dual-port synchronous RAM (one write, one registered read)
// with a reset-triggered clear sweep.
// Build option: HOB_RAM_BYPASS_EN forwards write data onto q for a
// same-address read-during-write; otherwise the old word is returned.
module hob_ram
    import hob_ram_pkg::*;
#(
    parameter int                WIDTH      = DEFAULT_WIDTH,
    parameter int                DEPTH      = DEFAULT_DEPTH,
    parameter int                ADDR_W     = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]  INIT_VALUE = WIDTH'(DEFAULT_INIT_VALUE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    output logic [WIDTH-1:0]  q,
    output logic              init_busy
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_wren;
    logic              user_we;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;

    hob_ram_init #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .clr_addr  (clr_addr),
        .clr_wren  (clr_wren)
    );

    // User writes are dropped (not queued) while the sweep owns the port
    assign user_we = wren & ~init_busy & ~reset;

    // Write-port mux: sweep has priority over the user port
    always_comb begin
        we = user_we;
        wa = wraddress;
        wd = data;
        if (clr_wren) begin
            we = 1'b1;
            wa = clr_addr;
            wd = INIT_VALUE;
        end
    end

    // Memory array write
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // Registered read; held at INIT_VALUE while clearing
    always_ff @(posedge clk) begin
        if (reset || init_busy) begin
            q <= INIT_VALUE;
        end else begin
`ifdef HOB_RAM_BYPASS_EN
            q <= (user_we && (wraddress == rdaddress)) ? data : mem[rdaddress];
`else
            q <= mem[rdaddress];
`endif
        end
    end

endmodule

// File: tb/tb_hob_ram.sv
// tb_hob_ram: directed checks of hob_ram in the default 64x36 shape plus an
// INSN-shaped (256x32) instance for the address-span check.
module tb_hob_ram;
    import hob_ram_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [35:0] data = '0;
    logic [5:0]  wraddress = '0;
    logic        wren = 1'b0;
    logic [5:0]  rdaddress = '0;
    logic [35:0] q;
    logic        init_busy;

    logic [31:0] i_data = '0;
    logic [7:0]  i_wraddress = '0;
    logic        i_wren = 1'b0;
    logic [7:0]  i_rdaddress = '0;
    logic [31:0] i_q;
    logic        i_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hob_ram dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .q         (q),
        .init_busy (init_busy)
    );

    hob_ram #(.WIDTH(INSN_WIDTH), .DEPTH(INSN_DEPTH)) dut_insn (
        .clk       (clk),
        .reset     (reset),
        .data      (i_data),
        .wraddress (i_wraddress),
        .wren      (i_wren),
        .rdaddress (i_rdaddress),
        .q         (i_q),
        .init_busy (i_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks busy after each of the DEPTH edges that follow the last reset edge
    task automatic sweep_check(input string tag);
        for (int j = 1; j <= 64; j++) begin
            tick();
            if (j == 1)  chk({tag, "_q_held"}, q, 36'h0);
            if (j == 63) chk({tag, "_busy_63"}, {35'h0, init_busy}, 36'h1);
            if (j == 64) chk({tag, "_busy_fall"}, {35'h0, init_busy}, 36'h0);
        end
    endtask

    initial begin
        logic all_zero;
        logic [35:0] rdw_exp;

        // Reset held 2 cycles
        tick();
        reset = 1'b1;
        tick();
        chk("reset_busy", {35'h0, init_busy}, 36'h1);
        chk("reset_q", q, 36'h0);
        tick();
        reset = 1'b0;
        sweep_check("sweep1");

        // Every location cleared
        all_zero = 1'b1;
        for (int a = 0; a < 64; a++) begin
            rdaddress = 6'(a);
            tick();
            if (q !== 36'h0) all_zero = 1'b0;
        end
        chk("clear_all_zero", {35'h0, all_zero}, 36'h1);

        // Write then read
        wren = 1'b1; wraddress = 6'd5; data = 36'h9_ABCD_1234;
        tick();
        wren = 1'b0; rdaddress = 6'd5;
        tick();
        chk("wr_rd_5", q, 36'h9_ABCD_1234);

        // Same-address read-during-write
        wren = 1'b1; wraddress = 6'd7; data = 36'h1;
        tick();
        data = 36'h2; rdaddress = 6'd7;
        tick();
`ifdef HOB_RAM_BYPASS_EN
        rdw_exp = 36'h2;
`else
        rdw_exp = 36'h1;
`endif
        chk("rdw_same", q, rdw_exp);
        wren = 1'b0;
        tick();
        chk("rdw_after", q, 36'h2);

        // Different-address read alongside a write
        wren = 1'b1; wraddress = 6'd10; data = 36'h5_A5A5_A5A5; rdaddress = 6'd5;
        tick();
        chk("rd_other_during_wr", q, 36'h9_ABCD_1234);
        wren = 1'b0; rdaddress = 6'd10;
        tick();
        chk("wr_rd_10", q, 36'h5_A5A5_A5A5);

        // Reset, then reset again at clr_addr=30, with a write held throughout
        wren = 1'b1; wraddress = 6'd3; data = 36'hF; rdaddress = 6'd5;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        chk("mid_busy", {35'h0, init_busy}, 36'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep_check("sweep2");
        wren = 1'b0;

        rdaddress = 6'd3;
        tick();
        chk("wr_during_sweep_3", q, 36'h0);
        rdaddress = 6'd10;
        tick();
        chk("cleared_10", q, 36'h0);
        rdaddress = 6'd7;
        tick();
        chk("cleared_7", q, 36'h0);
        rdaddress = 6'd63;
        tick();
        chk("cleared_63", q, 36'h0);

        // Post-sweep writes accepted
        wren = 1'b1; wraddress = 6'd63; data = 36'hF_FFFF_FFFF;
        tick();
        wren = 1'b0; rdaddress = 6'd63;
        tick();
        chk("wr_rd_63", q, 36'hF_FFFF_FFFF);

        // INSN shape: wait (bounded) for its longer sweep
        for (int k = 0; k < 400 && i_busy !== 1'b0; k++) tick();
        chk("insn_sweep_done", {35'h0, i_busy}, 36'h0);
        i_wren = 1'b1; i_wraddress = 8'd255; i_data = 32'hDEAD_BEEF;
        tick();
        i_wraddress = 8'd0; i_data = 32'h1;
        tick();
        i_wren = 1'b0; i_rdaddress = 8'd255;
        tick();
        chk("insn_255", {4'h0, i_q}, 36'hDEAD_BEEF);
        i_rdaddress = 8'd0;
        tick();
        chk("insn_0", {4'h0, i_q}, 36'h1);
        i_rdaddress = 8'd127;
        tick();
        chk("insn_127", {4'h0, i_q}, 36'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hob_ram.md
# hob_ram

Parameterized simple dual-port synchronous RAM: one write port, one read port, one clock. It backs the perceptron weight tables in the branch predictor, in its default 64 x 36 configuration. The same block, re-parameterized, also serves as the 256 x 32 instruction store and the 16 x 32 return-address stack. For the return-address stack, the read and write addresses are tied together to form a single-port memory. A synchronous reset runs a hardware clear sweep so that predictor state starts at a known value.

## Interface
- WIDTH, 36: data word width in bits.
- DEPTH, 64: number of words; must be a power of two, 2 or more.
- ADDR_W, $clog2(DEPTH): address width.
- INIT_VALUE, 0: word value written to every location by the clear sweep.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; starts the clear sweep.
- data  in  WIDTH  write data.
- wraddress  in  ADDR_W  write address.
- wren  in  1  write enable.
- rdaddress  in  ADDR_W  read address, sampled on each rising edge.
- q  out  WIDTH  read data, registered.
- init_busy  out  1  high while the clear sweep is in progress.

## Operation
- Write: on an edge with wren=1 and init_busy=0, mem[wraddress] takes the value of data.
- Read:
  - On every edge, q takes mem[rdaddress].
  - Reads proceed whether or not a write happens on the same edge.
- Read-during-write to the same address (the HOB_RAM_BYPASS_EN macro is described under Configuration):
  - Default: q returns the old word.
  - With HOB_RAM_BYPASS_EN defined: q returns the new data.
- Clear sweep states:
  - IDLE: normal operation.
  - CLEAR: an internal counter clr_addr steps 0 up to DEPTH-1. One location per cycle is written with INIT_VALUE. After the write to DEPTH-1, the state returns to IDLE.
- Entering CLEAR:
  - An edge with reset=1 forces CLEAR with clr_addr=0, from any state.
  - Reset asserted part-way through a sweep restarts the sweep at address 0.
  - Holding reset high keeps clr_addr at 0. The count begins on the first edge with reset=0.
- During CLEAR:
  - User writes (wren) are ignored and dropped, not queued.
  - q is held at INIT_VALUE.
- Address range: addresses never go out of range because ADDR_W exactly spans DEPTH. Out-of-range handling is not needed.

## Timing
- Read latency: 1 cycle. rdaddress presented before edge N appears on q after edge N.
- A word written at edge N is visible to a read that samples its address at edge N+1.
- Values on and after the edge with reset=1:
  - init_busy=1.
  - q=INIT_VALUE.
- Clear sweep duration: DEPTH+1 edges from the last reset edge until init_busy=0.
  - This counts the reset edge plus DEPTH clear writes, the last at clr_addr=DEPTH-1.
  - The first user write is accepted on the edge after init_busy falls.
- Before the first reset, memory contents and q are undefined.
- No handshake: the port accepts one write and one read every cycle.

## Configuration
- HOB_RAM_BYPASS_EN defined: same-address read-during-write forwards data onto q. This adds a comparator and a WIDTH-bit mux.
- HOB_RAM_BYPASS_EN undefined: old-data read-during-write. This is the behaviour of the plain inferred block RAM.

## Structure
- Package hob_ram_pkg holds:
  - the default WIDTH, DEPTH and INIT_VALUE;
  - the named configurations: HOB (64x36), INSN (256x32), RAS (16x32);
  - the sweep state enum {IDLE, CLEAR}.
- Sub-module hob_ram_init holds the clear sweep state machine and counter.
  - Inputs: clk, reset.
  - Outputs: init_busy, clr_addr, clr_wren.
- The top level muxes the sweep port onto the write port and infers the memory array.

## Test plan
- Reset then sweep, in the default configuration:
  - Assert reset for 2 cycles, then release. Check init_busy stays high for 65 edges counted from the last reset edge, then falls.
  - Then read addresses 0..63. Every q must be 0.
- Write then read: write 36'h9_ABCD_1234 to address 5, then read address 5 on the next cycle. q must be 36'h9_ABCD_1234 one cycle after the read address is presented.
- Same-address read-during-write: preload address 7 with 36'h1, then write 36'h2 to address 7 while reading address 7.
  - Without the macro: q=36'h1.
  - With HOB_RAM_BYPASS_EN: q=36'h2.
  - The next read of address 7 gives 36'h2 in both builds.
- Reset mid-sweep: assert reset again when clr_addr=30. The sweep must restart at 0 and take a full DEPTH+1 edges. A location written before the second reset must read back as INIT_VALUE.
- Write during sweep: hold wren=1 to address 3 with data 36'hF during CLEAR. After the sweep, address 3 must read 0.
- INSN configuration (WIDTH=32, DEPTH=256): write 32'hDEAD_BEEF to address 255 and 32'h1 to address 0. Both must read back correctly with no aliasing.
